dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (load/store cache).
- Requester 0 is the CPU load/store path. Requester 1 is a DMA/debug loader that fills or inspects data memory at runtime.
- Latches one request at a time, drives the memory's memread/memwrite/addr/write_data/sign_mask, tracks the memory's clk_stall handshake, and returns read data plus a completion pulse to the winner.
- CPU has priority; a starvation counter guarantees DMA progress.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- STARVE_MAX, 4, consecutive CPU grants allowed while dma_req is pending before DMA is forced to win; range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_sign_mask  in  4  {sign, size mask}: 001 byte, 011 half, 111 word
- cpu_stall  out  1  high while cpu_req is pending and not yet done
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid when cpu_done is high, held until the next CPU read completes
- dma_req, dma_we, dma_addr, dma_wdata, dma_sign_mask  in  as CPU  DMA request fields
- dma_done  out  1  one-cycle completion pulse
- dma_rdata  out  DATA_W  as cpu_rdata
- mem_memread  out  1  one-cycle read strobe to memory
- mem_memwrite  out  1  one-cycle write strobe to memory
- mem_addr  out  ADDR_W  latched address
- mem_write_data  out  DATA_W  latched write data
- mem_sign_mask  out  4  latched sign mask
- mem_clk_stall  in  1  memory busy; rises the cycle after a strobe and falls when the access completes
- mem_read_data  in  DATA_W  valid on the cycle mem_clk_stall is first seen low after being high

Behaviour:
- Reset values:
  - State = IDLE.
  - All strobes, done pulses, mem_addr, mem_write_data, mem_sign_mask, cpu_rdata, dma_rdata = 0.
  - Starvation counter = 0.
- States: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> RESP -> IDLE.
- IDLE:
  - Arbitrates only when mem_clk_stall == 0 and at least one request is present.
  - Winner: DMA if dma_req and starve_cnt == STARVE_MAX, otherwise CPU if cpu_req, otherwise DMA.
  - Latches the winner's we/addr/wdata/sign_mask and owner bit, then goes to ISSUE.
- ISSUE: drives mem_memread = !we or mem_memwrite = we for exactly one cycle, then goes to WAIT_ACK.
- WAIT_ACK: waits for mem_clk_stall == 1, then goes to WAIT_DONE.
- WAIT_DONE:
  - Waits for mem_clk_stall == 0.
  - On that cycle, captures mem_read_data into the owner's rdata register (reads only; write completion leaves rdata unchanged), then goes to RESP.
- RESP: pulses the owner's done for one cycle, then returns to IDLE. A new request can be granted on the following cycle.
- Latency: grant to done = 5 cycles, plus any extra memory stall cycles.
- cpu_stall = cpu_req & ~cpu_done (combinational), so the CPU freezes for the whole access.
- Starvation counter:
  - Increments on a CPU grant while dma_req = 1, saturating at STARVE_MAX.
  - Clears on any DMA grant, or whenever dma_req = 0 in IDLE.
- Simultaneous requests: CPU wins unless the counter is at STARVE_MAX.
- A requester dropping req mid-transaction is a protocol violation. The transaction completes regardless and done still pulses.
- Request field changes after grant are ignored because fields are latched.
- Reset mid-operation: the arbiter returns to IDLE immediately. The IDLE rule (mem_clk_stall == 0 required) keeps it from issuing until any in-flight memory access drains.
- Addresses and masks pass through unaltered, including the LED address 0x2000 and misaligned offsets.
- A mem_clk_stall that never rises in WAIT_ACK hangs the arbiter. A timeout is out of scope.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined:
  - Adds output ports perf_cpu_grants[31:0], perf_dma_grants[31:0] and perf_wait_cycles[31:0].
  - perf_wait_cycles counts cycles in which a request is pending but not yet granted.
  - All three counters clear on reset, wrap at 2^32 and are readable at any time.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package dmem_pkg holds:
  - the state encoding (IDLE..RESP);
  - sign-mask constants SM_BYTE = 3'b001, SM_HALF = 3'b011, SM_WORD = 3'b111;
  - the LED address constant 32'h2000.
- One sub-module, dmem_arb_prio: pure arbitration logic plus the starvation counter, outputting the winner bit. The FSM and datapath latches stay in dmem_arbiter.

Test Plan:
- CPU read only: cpu_req = 1, addr 0x4008, word. Memory model stalls 2 cycles and returns 0xDEADBEEF -> mem_memread pulses once, cpu_rdata = 0xDEADBEEF, cpu_done 5 cycles after grant, dma_done stays 0.
- Simultaneous requests: CPU write 0x11 byte @0x4001 and DMA read @0x4000 -> CPU issued first; DMA issued in the cycle after cpu_done; dma_done follows.
- Starvation: cpu_req held continuously, dma_req held, STARVE_MAX = 4 -> grant sequence C,C,C,C,D,C,C,C,C,D.
- Reset mid-access: assert reset during WAIT_DONE while memory holds mem_clk_stall high 3 more cycles -> all outputs 0 and no strobe until mem_clk_stall falls; the next request then proceeds normally.
- Field change after grant: CPU changes cpu_addr from 0x4010 to 0x4020 during WAIT_ACK -> mem_addr stays 0x4010.
- With DMEM_ARB_PERF_EN: 3 CPU and 2 DMA accesses -> perf_cpu_grants = 3, perf_dma_grants = 2, and perf_wait_cycles matches the model's count.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and constants for the data-memory arbiter
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  localparam logic [2:0] SM_BYTE = 3'b001;
  localparam logic [2:0] SM_HALF = 3'b011;
  localparam logic [2:0] SM_WORD = 3'b111;

  localparam logic [31:0] LED_ADDR = 32'h0000_2000;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_prio.sv
// rtl/dmem_arb_prio.sv - CPU-priority arbitration with a starvation counter that forces DMA progress
module dmem_arb_prio
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic mem_busy,
  input  logic cpu_req,
  input  logic dma_req,
  output logic grant,
  output logic winner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  assign grant  = idle & ~mem_busy & (cpu_req | dma_req);
  assign winner = ((dma_req && starve_cnt == STARVE_LIM) || !cpu_req) ? OWNER_DMA : OWNER_CPU;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant && winner == OWNER_DMA) begin
      starve_cnt <= 4'd0;
    end else if (idle && !dma_req) begin
      starve_cnt <= 4'd0;
    end else if (grant && dma_req && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester sequencer in front of the single-port data memory
// Optional perf counters enabled by DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_sign_mask,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [3:0]        dma_sign_mask,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_sign_mask,
  input  logic              mem_clk_stall,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       perf_cpu_grants,
  output logic [31:0]       perf_dma_grants,
  output logic [31:0]       perf_wait_cycles,
`endif
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t state, state_next;
  logic   grant, winner, owner, we_q;
  logic   we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [3:0]        mask_sel;

  dmem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk      (clk),
    .reset    (reset),
    .idle     (state == ST_IDLE),
    .mem_busy (mem_clk_stall),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .grant    (grant),
    .winner   (winner)
  );

  assign cpu_stall = cpu_req & ~cpu_done;

  always_comb begin
    we_sel    = cpu_we;
    addr_sel  = cpu_addr;
    wdata_sel = cpu_wdata;
    mask_sel  = cpu_sign_mask;
    if (winner == OWNER_DMA) begin
      we_sel    = dma_we;
      addr_sel  = dma_addr;
      wdata_sel = dma_wdata;
      mask_sel  = dma_sign_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (grant) state_next = ST_ISSUE;
      ST_ISSUE:     state_next = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (mem_clk_stall) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!mem_clk_stall) state_next = ST_RESP;
      ST_RESP:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Strobes are registered on the grant edge so they are visible during ISSUE;
  // done is registered on completion so it is visible during RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner          <= OWNER_CPU;
      we_q           <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      cpu_done       <= 1'b0;
      dma_done       <= 1'b0;
      cpu_rdata      <= '0;
      dma_rdata      <= '0;
    end else begin
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      cpu_done     <= 1'b0;
      dma_done     <= 1'b0;
      if (grant) begin
        owner          <= winner;
        we_q           <= we_sel;
        mem_addr       <= addr_sel;
        mem_write_data <= wdata_sel;
        mem_sign_mask  <= mask_sel;
        mem_memread    <= ~we_sel;
        mem_memwrite   <= we_sel;
      end
      if (state == ST_WAIT_DONE && !mem_clk_stall) begin
        if (owner == OWNER_CPU) begin
          cpu_done <= 1'b1;
          if (!we_q) cpu_rdata <= mem_read_data;
        end else begin
          dma_done <= 1'b1;
          if (!we_q) dma_rdata <= mem_read_data;
        end
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // A requester is waiting when it asks but neither owns the transaction in flight nor wins this cycle.
  logic busy, cpu_served, dma_served;

  always_comb begin
    busy       = (state != ST_IDLE);
    cpu_served = (busy && owner == OWNER_CPU) || (grant && winner == OWNER_CPU);
    dma_served = (busy && owner == OWNER_DMA) || (grant && winner == OWNER_DMA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cpu_grants  <= 32'd0;
      perf_dma_grants  <= 32'd0;
      perf_wait_cycles <= 32'd0;
    end else begin
      if (grant && winner == OWNER_CPU) perf_cpu_grants <= perf_cpu_grants + 32'd1;
      if (grant && winner == OWNER_DMA) perf_dma_grants <= perf_dma_grants + 32'd1;
      if ((cpu_req && !cpu_served) || (dma_req && !dma_served))
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a stalling memory model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_sign_mask = '0;
  logic        cpu_stall, cpu_done;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [3:0]  dma_sign_mask = '0;
  logic        dma_done;
  logic [31:0] dma_rdata;
  logic        mem_memread, mem_memwrite;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_clk_stall = 1'b0;
  logic [31:0] mem_read_data = '0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_grants, perf_dma_grants, perf_wait_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 2;
  int dma_done_cnt = 0;
  logic [3:0]  stall_cnt = '0;
  logic [31:0] mem_model [logic [31:0]];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_sign_mask  (cpu_sign_mask),
    .cpu_stall      (cpu_stall),
    .cpu_done       (cpu_done),
    .cpu_rdata      (cpu_rdata),
    .dma_req        (dma_req),
    .dma_we         (dma_we),
    .dma_addr       (dma_addr),
    .dma_wdata      (dma_wdata),
    .dma_sign_mask  (dma_sign_mask),
    .dma_done       (dma_done),
    .dma_rdata      (dma_rdata),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_sign_mask  (mem_sign_mask),
    .mem_clk_stall  (mem_clk_stall),
`ifdef DMEM_ARB_PERF_EN
    .perf_cpu_grants  (perf_cpu_grants),
    .perf_dma_grants  (perf_dma_grants),
    .perf_wait_cycles (perf_wait_cycles),
`endif
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: stall rises the cycle after a strobe and stays high for lat cycles; never reset.
  always @(posedge clk) begin
    if (mem_memread || mem_memwrite) begin
      mem_clk_stall <= 1'b1;
      stall_cnt     <= 4'(lat - 1);
      if (mem_memwrite) mem_model[mem_addr] = mem_write_data;
      else mem_read_data <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
    end else if (stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 4'd1;
    end else begin
      mem_clk_stall <= 1'b0;
    end
  end

  always @(negedge clk) if (dma_done) dma_done_cnt <= dma_done_cnt + 1;

  task automatic wait_strobe(output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (mem_memread || mem_memwrite) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic wait_done(input bit dma, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (dma ? dma_done : cpu_done) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({mem_memread, mem_memwrite, cpu_done, dma_done} !== 4'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {mem_memread, mem_memwrite, cpu_done, dma_done}); end
    checks++; if ({mem_addr, mem_write_data, mem_sign_mask} !== 68'h0) begin errors++; $display("FAIL reset_mem_fields got=%h/%h/%h exp=0", mem_addr, mem_write_data, mem_sign_mask); end
    checks++; if ({cpu_rdata, dma_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", cpu_rdata, dma_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall got=%b exp=0", cpu_stall); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    int g, s, d, reads0;
    bit ok;
    mem_model[32'h4008] = 32'hDEADBEEF;
    lat = 2;
    reads0 = dma_done_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4008; cpu_sign_mask = {1'b0, 3'b111};
    g = cyc;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL cpu_stall_pending got=%b exp=1", cpu_stall); end
    wait_strobe(s, ok);
    checks++; if (!ok || s != g + 1 || mem_memread !== 1'b1 || mem_memwrite !== 1'b0) begin errors++; $display("FAIL cpu_read_strobe got cyc=%0d rd=%b wr=%b exp cyc=%0d rd=1 wr=0", s, mem_memread, mem_memwrite, g + 1); end
    checks++; if (mem_addr !== 32'h4008 || mem_sign_mask !== 4'b0111) begin errors++; $display("FAIL cpu_read_addr got=%h/%b exp=00004008/0111", mem_addr, mem_sign_mask); end
    @(negedge clk);
    checks++; if (mem_memread !== 1'b0) begin errors++; $display("FAIL cpu_read_single_strobe got=%b exp=0", mem_memread); end
    wait_done(1'b0, d, ok);
    checks++; if (!ok || d != g + 5) begin errors++; $display("FAIL cpu_read_latency got=%0d exp=%0d", d - g, 5); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_read_rdata got=%h exp=deadbeef", cpu_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_stall_at_done got=%b exp=0", cpu_stall); end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_rdata !== 32'hDEADBEEF || cpu_done !== 1'b0) begin errors++; $display("FAIL cpu_rdata_hold got=%h done=%b exp=deadbeef done=0", cpu_rdata, cpu_done); end
    checks++; if (dma_done_cnt != reads0) begin errors++; $display("FAIL cpu_read_no_dma_done got=%0d exp=%0d", dma_done_cnt - reads0, 0); end
  endtask

  task automatic test_simultaneous();
    int s1, c, s2, d, dd0;
    bit ok;
    mem_model[32'h4000] = 32'h1234_5678;
    dd0 = dma_done_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4001; cpu_wdata = 32'h11; cpu_sign_mask = {1'b0, 3'b001};
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4000; dma_sign_mask = {1'b0, 3'b111};
    wait_strobe(s1, ok);
    checks++; if (!ok || mem_memwrite !== 1'b1 || mem_addr !== 32'h4001 || mem_write_data !== 32'h11 || mem_sign_mask !== 4'b0001) begin errors++; $display("FAIL simul_cpu_first got wr=%b addr=%h wd=%h m=%b exp wr=1 addr=00004001 wd=00000011 m=0001", mem_memwrite, mem_addr, mem_write_data, mem_sign_mask); end
    wait_done(1'b0, c, ok);
    checks++; if (!ok || dma_done_cnt != dd0) begin errors++; $display("FAIL simul_cpu_done_first got ok=%b dma_dones=%0d exp ok=1 dma_dones=0", ok, dma_done_cnt - dd0); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_keeps_rdata got=%h exp=deadbeef", cpu_rdata); end
    cpu_req = 1'b0;
    // DMA is granted the cycle after cpu_done, so its strobe lands one cycle later still.
    wait_strobe(s2, ok);
    checks++; if (!ok || s2 != c + 2 || mem_memread !== 1'b1 || mem_addr !== 32'h4000) begin errors++; $display("FAIL simul_dma_issue got cyc=%0d rd=%b addr=%h exp cyc=%0d rd=1 addr=00004000", s2, mem_memread, mem_addr, c + 2); end
    wait_done(1'b1, d, ok);
    checks++; if (!ok || d != s2 + 4) begin errors++; $display("FAIL simul_dma_latency got=%0d exp=4", d - s2); end
    checks++; if (dma_rdata !== 32'h1234_5678) begin errors++; $display("FAIL simul_dma_rdata got=%h exp=12345678", dma_rdata); end
    dma_req = 1'b0;
  endtask

  task automatic test_field_change();
    int s, d;
    bit ok;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4010; cpu_wdata = 32'hAA; cpu_sign_mask = {1'b0, 3'b111};
    wait_strobe(s, ok);
    @(posedge clk); #1;
    cpu_addr = 32'h4020; cpu_wdata = 32'hBB;
    wait_done(1'b0, d, ok);
    checks++; if (!ok || mem_addr !== 32'h4010 || mem_write_data !== 32'hAA) begin errors++; $display("FAIL field_latched got ok=%b addr=%h wd=%h exp addr=00004010 wd=000000aa", ok, mem_addr, mem_write_data); end
    checks++; if (!mem_model.exists(32'h4010) || mem_model[32'h4010] !== 32'hAA || mem_model.exists(32'h4020)) begin errors++; $display("FAIL field_mem_write got has4010=%b has4020=%b exp 1/0", mem_model.exists(32'h4010), mem_model.exists(32'h4020)); end
    cpu_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic [9:0] seq;
    int s, d;
    bit ok;
    bit all_ok;
    seq = '0; all_ok = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_sign_mask = 4'b0111;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; dma_sign_mask = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      wait_strobe(s, ok);
      all_ok = all_ok & ok;
      seq[i] = (mem_addr == 32'h200);
    end
    wait_done(1'b1, d, ok);
    cpu_req = 1'b0; dma_req = 1'b0;
    // Bit i set means grant i went to DMA: C,C,C,C,D,C,C,C,C,D.
    checks++; if (!all_ok || seq !== 10'b10_0001_0000) begin errors++; $display("FAIL starvation_seq got=%b exp=1000010000", seq); end
    checks++; if (!ok) begin errors++; $display("FAIL starvation_final_done got=timeout exp=dma_done"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int s, s2, d;
    bit ok;
    lat = 6;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4008; cpu_sign_mask = 4'b0111;
    wait_strobe(s, ok);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lat = 2;
    @(negedge clk);
    checks++; if ({mem_memread, mem_memwrite, cpu_done, dma_done} !== 4'b0 || mem_addr !== 32'h0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_mid_outputs got strobes=%b addr=%h rdata=%h exp 0", {mem_memread, mem_memwrite, cpu_done, dma_done}, mem_addr, cpu_rdata); end
    checks++; if (mem_clk_stall !== 1'b1) begin errors++; $display("FAIL reset_mid_mem_busy got=%b exp=1", mem_clk_stall); end
    wait_strobe(s2, ok);
    checks++; if (!ok || s2 != s + 8) begin errors++; $display("FAIL reset_mid_reissue got cyc=%0d exp=%0d", s2, s + 8); end
    wait_done(1'b0, d, ok);
    checks++; if (!ok || d != s2 + 4 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_mid_recover got lat=%0d rdata=%h exp lat=4 rdata=deadbeef", d - s2, cpu_rdata); end
    cpu_req = 1'b0;
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic run_solo(input bit dma, input logic [31:0] addr);
    int d;
    bit ok;
    @(posedge clk); #1;
    if (dma) begin dma_req = 1'b1; dma_we = 1'b0; dma_addr = addr; end
    else begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; end
    wait_done(dma, d, ok);
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_perf();
    int d;
    bit ok;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if ({perf_cpu_grants, perf_dma_grants, perf_wait_cycles} !== 96'h0) begin errors++; $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", perf_cpu_grants, perf_dma_grants, perf_wait_cycles); end
    run_solo(1'b0, 32'h300);
    run_solo(1'b0, 32'h304);
    @(posedge clk); #1;
    cpu_req = 1'b1; dma_req = 1'b1;
    wait_done(1'b0, d, ok);
    cpu_req = 1'b0;
    wait_done(1'b1, d, ok);
    dma_req = 1'b0;
    run_solo(1'b1, 32'h308);
    @(negedge clk);
    checks++; if (perf_cpu_grants !== 32'd3) begin errors++; $display("FAIL perf_cpu_grants got=%0d exp=3", perf_cpu_grants); end
    checks++; if (perf_dma_grants !== 32'd2) begin errors++; $display("FAIL perf_dma_grants got=%0d exp=2", perf_dma_grants); end
    checks++; if (perf_wait_cycles !== 32'd6) begin errors++; $display("FAIL perf_wait_cycles got=%0d exp=6", perf_wait_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_field_change();
    test_starvation();
    test_reset_mid();
`ifdef DMEM_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
